// File: rtl/axi_uart_tx_arb_pkg.sv
// Shared types and helpers for the UART TX packet arbiter.
package axi_uart_tx_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/axi_uart_tx_arb_rr_pick.sv
// Combinational round-robin selector: lowest request strictly above the
// one-hot last pointer wins, otherwise wrap to the lowest request overall.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] last_i,
  output logic [N-1:0] pick_o
);

  logic [N-1:0] above_mask;
  logic [N-1:0] masked_req;
  logic [N-1:0] pick_above;
  logic [N-1:0] pick_wrap;

  // (last << 1) - 1 covers bits 0..last; its complement is everything above.
  assign above_mask = ~((last_i << 1) - N'(1));
  assign masked_req = req_i & above_mask;

  // x & -x isolates the lowest set bit.
  assign pick_above = masked_req & (~masked_req + N'(1));
  assign pick_wrap  = req_i & (~req_i + N'(1));

  assign pick_o = (|masked_req) ? pick_above : pick_wrap;

endmodule

// File: rtl/axi_uart_tx_arb.sv
// Round-robin packet arbiter sharing one UART TX byte stream between
// several AXI-stream requesters, with a per-grant burst limit.
module axi_uart_tx_arb
  import axi_uart_tx_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_PORTS*8-1:0] s_tdata,
  input  logic [NUM_PORTS-1:0]   s_tlast,
  input  logic [NUM_PORTS-1:0]   s_tvalid,
  output logic [NUM_PORTS-1:0]   s_tready,
  input  logic [NUM_PORTS-1:0]   en_mask,
  output logic [7:0]             m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [NUM_PORTS-1:0]   grant,
  output logic                   busy
);

  localparam int CW = clog2(MAX_BURST + 1);
  localparam logic [NUM_PORTS-1:0] PTR_RST = {1'b1, {(NUM_PORTS-1){1'b0}}};

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [NUM_PORTS-1:0] ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_PORTS-1:0] pick;
  logic [NUM_PORTS-1:0] req;
  logic                 sel_valid;
  logic                 sel_last;
  logic [7:0]           sel_data;
  logic                 hs;
  logic                 burst_end;

  assign req = s_tvalid & en_mask;

  rr_pick #(.N(NUM_PORTS)) u_rr_pick (
    .req_i  (req),
    .last_i (ptr_q),
    .pick_o (pick)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (grant_q[k]) begin
        sel_valid = s_tvalid[k];
        sel_last  = s_tlast[k];
        sel_data  = s_tdata[8*k +: 8];
      end
    end
  end

  // grant_q is zero outside XFER, so gating on busy only guards the data bus.
  assign busy      = (state_q == XFER);
  assign m_tvalid  = busy & sel_valid;
  assign m_tdata   = busy ? sel_data : 8'h00;
  assign s_tready  = (busy & m_tready) ? grant_q : '0;
  assign grant     = grant_q;
  assign hs        = m_tvalid & m_tready;
  assign burst_end = (cnt_q == CW'(MAX_BURST - 1));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|pick) begin
          state_d = XFER;
          grant_d = pick;
          ptr_d   = pick;
          cnt_d   = '0;
        end
      end
      XFER: begin
        if (hs) begin
          if (cnt_q != CW'(MAX_BURST)) begin
            cnt_d = cnt_q + CW'(1);
          end
          if (sel_last || burst_end) begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_uart_tx_arb.sv
// Self-checking bench for axi_uart_tx_arb: per-cycle reference model plus
// literal byte-order expectations for each directed scenario.
module tb_axi_uart_tx_arb;

  localparam int NP = 4;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NP*8-1:0] s_tdata = '0;
  logic [NP-1:0] s_tlast = '0;
  logic [NP-1:0] s_tvalid = '0;
  logic [NP-1:0] s_tready;
  logic [NP-1:0] en = '1;
  logic [7:0]    m_tdata;
  logic          m_tvalid;
  logic          mr = 1'b1;
  logic [NP-1:0] grant;
  logic          busy;

  always #5 clk = ~clk;

  axi_uart_tx_arb #(.NUM_PORTS(NP), .MAX_BURST(MB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  (s_tdata),
    .s_tlast  (s_tlast),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .en_mask  (en),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (mr),
    .grant    (grant),
    .busy     (busy)
  );

  logic [8:0]    srcq [NP][$];
  logic [7:0]    got [$];
  logic [7:0]    expq [$];
  logic [NP-1:0] pop = '0;
  int            m_own = -1;
  int            m_ptr = NP - 1;
  int            m_cnt = 0;
  int            total = 0;
  int            bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic drive();
    logic [8:0] h;
    for (int k = 0; k < NP; k++) begin
      if (srcq[k].size() > 0) begin
        h = srcq[k][0];
        s_tvalid[k] = 1'b1;
        s_tdata[8*k +: 8] = h[7:0];
        s_tlast[k] = h[8];
      end else begin
        s_tvalid[k] = 1'b0;
        s_tdata[8*k +: 8] = 8'h00;
        s_tlast[k] = 1'b0;
      end
    end
  endtask

  task automatic send(input int port, input logic [7:0] b, input logic last);
    srcq[port].push_back({last, b});
  endtask

  // Reference model: owner index (or -1), last-winner index, bytes in grant.
  task automatic check_cycle();
    logic [17:0] act, expv;
    logic [NP-1:0] eg, es, rq;
    logic eb, ev;
    logic [7:0] ed;
    int c;
    act = {grant, busy, m_tvalid, m_tdata, s_tready};
    eg = '0; es = '0; eb = 1'b0; ev = 1'b0; ed = 8'h00;
    if (!rst_n) begin
      m_own = -1; m_ptr = NP - 1; m_cnt = 0;
    end else if (m_own < 0) begin
      rq = s_tvalid & en;
      for (int k = 1; k <= NP; k++) begin
        c = (m_ptr + k) % NP;
        if (m_own < 0 && rq[c]) begin
          m_own = c; m_ptr = c; m_cnt = 0;
        end
      end
    end else begin
      eg[m_own] = 1'b1;
      eb = 1'b1;
      ev = s_tvalid[m_own];
      ed = s_tdata[8*m_own +: 8];
      es[m_own] = mr;
      if (ev && mr) begin
        m_cnt++;
        if (s_tlast[m_own] || m_cnt == MB) m_own = -1;
      end
    end
    expv = {eg, eb, ev, ed, es};
    check($sformatf("cycle t=%0t {grant,busy,vld,data,rdy}", $time), 32'(act), 32'(expv));
    pop = s_tvalid & s_tready;
    if (m_tvalid && mr) begin
      got.push_back(m_tdata);
      $display("xfer t=%0t grant=%b data=%02h", $time, grant, m_tdata);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    for (int k = 0; k < NP; k++) begin
      if (pop[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
    end
    drive();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < NP; k++) srcq[k].delete();
    mr = 1'b1;
    en = '1;
    drive();
    tick();
    tick();
    rst_n = 1'b1;
    got.delete();
  endtask

  task automatic drain(input string name, input int max_cycles);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      done = (srcq[0].size() == 0) && (srcq[1].size() == 0) && (srcq[2].size() == 0) &&
             (srcq[3].size() == 0) && !busy && (m_own < 0);
      if (done) break;
      tick();
    end
    check({name, " drain"}, 32'(done), 32'd1);
  endtask

  task automatic expect_bytes(input string name);
    check({name, " count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++) begin
      check($sformatf("%s byte%0d", name, i), 32'(got[i]), 32'(expq[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    check("rst grant", 32'(grant), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst m_tvalid", 32'(m_tvalid), 32'h0);
    check("rst s_tready", 32'(s_tready), 32'h0);

    // 1: port 1 sends a 3-byte packet
    send(1, 8'h41, 1'b0); send(1, 8'h42, 1'b0); send(1, 8'h43, 1'b1);
    drive();
    tick();
    check("t1 grant", 32'(grant), 32'b0010);
    check("t1 m_tvalid", 32'(m_tvalid), 32'h1);
    check("t1 m_tdata", 32'(m_tdata), 32'h41);
    drain("t1", 50);
    check("t1 grant after", 32'(grant), 32'h0);
    check("t1 busy after", 32'(busy), 32'h0);
    expq = '{8'h41, 8'h42, 8'h43};
    expect_bytes("t1");

    // 2: all ports with 1-byte packets, port 0 refilled
    do_reset();
    send(0, 8'hA0, 1'b1); send(0, 8'hA0, 1'b1);
    send(1, 8'hA1, 1'b1); send(2, 8'hA2, 1'b1); send(3, 8'hA3, 1'b1);
    drive();
    drain("t2", 50);
    expq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    expect_bytes("t2");

    // 3: burst limit forces release mid-packet
    do_reset();
    for (int i = 0; i < 20; i++) send(0, 8'(i), (i == 19) ? 1'b1 : 1'b0);
    send(2, 8'h55, 1'b1);
    drive();
    drain("t3", 100);
    expq.delete();
    for (int i = 0; i < 16; i++) expq.push_back(8'(i));
    expq.push_back(8'h55);
    for (int i = 16; i < 20; i++) expq.push_back(8'(i));
    expect_bytes("t3");

    // 4: port 2 masked; port 0 disabled mid-packet still completes
    do_reset();
    en = 4'b1011;
    send(0, 8'h10, 1'b0); send(0, 8'h11, 1'b1);
    send(1, 8'h20, 1'b1); send(2, 8'h30, 1'b1); send(3, 8'h40, 1'b1);
    drive();
    tick();
    check("t4 grant", 32'(grant), 32'b0001);
    en = 4'b1010;
    for (int i = 0; i < 16; i++) tick();
    check("t4 port2 pending", srcq[2].size(), 1);
    expq = '{8'h10, 8'h11, 8'h20, 8'h40};
    expect_bytes("t4");

    // 5: stalled m_tready during a 4-byte packet
    do_reset();
    send(1, 8'h61, 1'b0); send(1, 8'h62, 1'b0); send(1, 8'h63, 1'b0); send(1, 8'h64, 1'b1);
    drive();
    tick();
    for (int i = 0; i < 6; i++) begin
      mr = (i == 1 || i == 2) ? 1'b0 : 1'b1;
      #1;
      if (i == 0) check("t5 s_tready mirror", 32'(s_tready), 32'b0010);
      if (i == 2) begin
        check("t5 stall data", 32'(m_tdata), 32'h62);
        check("t5 stall valid", 32'(m_tvalid), 32'h1);
        check("t5 stall ready", 32'(s_tready), 32'h0);
      end
      tick();
    end
    mr = 1'b1;
    drain("t5", 20);
    expq = '{8'h61, 8'h62, 8'h63, 8'h64};
    expect_bytes("t5");

    // 6: async reset mid-packet on port 3
    do_reset();
    send(3, 8'h71, 1'b0); send(3, 8'h72, 1'b0); send(3, 8'h73, 1'b1);
    drive();
    tick();
    check("t6 grant p3", 32'(grant), 32'b1000);
    tick();
    rst_n = 1'b0;
    #1;
    check("t6 async grant", 32'(grant), 32'h0);
    check("t6 async m_tvalid", 32'(m_tvalid), 32'h0);
    check("t6 async s_tready", 32'(s_tready), 32'h0);
    send(0, 8'h01, 1'b1);
    drive();
    tick();
    rst_n = 1'b1;
    tick();
    check("t6 port0 wins", 32'(grant), 32'b0001);
    drain("t6", 50);
    expq = '{8'h71, 8'h01, 8'h72, 8'h73};
    expect_bytes("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
